// File: rtl/mux_scan_sampler_pkg.sv
// Shared definitions for the 16:1 mux scan sampler: FSM states, channel geometry,
// and settle-counter sizing.
package mux_scan_sampler_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Counter reload value: a channel is held for `settle` cycles, and the counter counts down to zero.
  function automatic logic [CNT_W-1:0] settle_reload(input int unsigned settle);
    return CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/mux_scan_sampler_settle.sv
// Settle-time down-counter: loads a reload value and decrements to zero when enabled.
module mux_scan_sampler_settle
  import mux_scan_sampler_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// Sweeps the 16:1 mux select, samples each channel after a settle time and
// hands the 16-bit snapshot downstream over valid/ready, stalling rather than dropping.
module mux_scan_sampler
  import mux_scan_sampler_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              mux_y,
  input  logic              ready,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] data,
  output logic              valid,
  output logic              busy
);

  localparam logic [CNT_W-1:0] RELOAD  = settle_reload(SETTLE_CYCLES);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  state_t state, state_nxt;

  // Bits 0..14 hold the scan's samples; bit 15 only holds the last sample while stalled in HOLD.
  logic [NUM_CH-1:0] shadow;

  logic cnt_zero;
  logic cnt_load;
  logic cnt_dec;
  logic sample_en;
  logic sel_inc;
  logic sel_clr;
  logic load_word;
  logic load_hold;
  logic cap_extra;
  logic out_free;

  assign out_free = !valid || ready;
  assign busy     = (state != ST_IDLE);

  mux_scan_sampler_settle #(
    .WIDTH(CNT_W)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (RELOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    sample_en = 1'b0;
    sel_inc   = 1'b0;
    sel_clr   = 1'b0;
    load_word = 1'b0;
    load_hold = 1'b0;
    cap_extra = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SCAN;
          sel_clr   = 1'b1;
          cnt_load  = 1'b1;
        end
      end

      ST_SCAN: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (sel != LAST_CH) begin
          sample_en = 1'b1;
          sel_inc   = 1'b1;
          cnt_load  = 1'b1;
        end else if (out_free) begin
          load_word = 1'b1;
          if (cont) begin
            sel_clr  = 1'b1;
            cnt_load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cap_extra = 1'b1;
          state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (ready) begin
          load_hold = 1'b1;
          if (cont) begin
            state_nxt = ST_SCAN;
            sel_clr   = 1'b1;
            cnt_load  = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= '0;
      shadow <= '0;
      data   <= '0;
      valid  <= 1'b0;
    end else begin
      if (sel_clr) begin
        sel <= '0;
      end else if (sel_inc) begin
        sel <= sel + 1'b1;
      end

      if (sample_en) begin
        shadow[sel] <= mux_y;
      end
      if (cap_extra) begin
        shadow[NUM_CH-1] <= mux_y;
      end

      if (load_word) begin
        data <= {mux_y, shadow[NUM_CH-2:0]};
      end else if (load_hold) begin
        data <= shadow;
      end

      // A word loading on the transfer edge keeps valid high; otherwise a transfer clears it.
      if (load_word || load_hold) begin
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: three instances (settle 1/2/3) each driving
// a behavioural 16:1 mux over a static pattern X.
module tb_mux_scan_sampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cont;
  logic        ready;
  logic [15:0] x;

  logic [3:0]  sel1, sel2, sel3;
  logic [15:0] data1, data2, data3;
  logic        valid1, valid2, valid3;
  logic        busy1, busy2, busy3;
  logic        mux_y1, mux_y2, mux_y3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign mux_y1 = x[sel1];
  assign mux_y2 = x[sel2];
  assign mux_y3 = x[sel3];

  mux_scan_sampler #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .mux_y(mux_y1),
    .ready(ready), .sel(sel1), .data(data1), .valid(valid1), .busy(busy1)
  );

  mux_scan_sampler #(.SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .mux_y(mux_y2),
    .ready(ready), .sel(sel2), .data(data2), .valid(valid2), .busy(busy2)
  );

  mux_scan_sampler #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .mux_y(mux_y3),
    .ready(ready), .sel(sel3), .data(data3), .valid(valid3), .busy(busy3)
  );

  typedef struct {
    logic        start;
    logic        ready;
    logic        cont;
    logic [3:0]  sel;
    logic        valid;
    logic        busy;
    logic [15:0] data;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    cont  = 1'b0;
    ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    start = 1'b0;
    cont  = 1'b0;
    ready = 1'b0;
    x     = 16'hA5C3;
    rst_n = 1'b0;
    #2;

    // Reset state, before any clock edge.
    check("reset_sel",   16'(sel1),   16'h0);
    check("reset_data",  data1,       16'h0);
    check("reset_valid", 16'(valid1), 16'h0);
    check("reset_busy",  16'(busy1),  16'h0);
    tick();
    rst_n = 1'b1;

    // Single scan, settle 1: sel ramps 0..15 one cycle each, word at E16.
    tbl[0].start = 1'b1; tbl[0].ready = 1'b1; tbl[0].cont = 1'b0;
    tbl[0].sel = 4'd0; tbl[0].valid = 1'b0; tbl[0].busy = 1'b1; tbl[0].data = 16'h0000;
    for (int i = 1; i < 16; i++) begin
      tbl[i].start = 1'b0; tbl[i].ready = 1'b1; tbl[i].cont = 1'b0;
      tbl[i].sel = 4'(i); tbl[i].valid = 1'b0; tbl[i].busy = 1'b1; tbl[i].data = 16'h0000;
    end
    tbl[16].start = 1'b0; tbl[16].ready = 1'b1; tbl[16].cont = 1'b0;
    tbl[16].sel = 4'd15; tbl[16].valid = 1'b1; tbl[16].busy = 1'b0; tbl[16].data = 16'hA5C3;
    tbl[17].start = 1'b0; tbl[17].ready = 1'b1; tbl[17].cont = 1'b0;
    tbl[17].sel = 4'd15; tbl[17].valid = 1'b0; tbl[17].busy = 1'b0; tbl[17].data = 16'hA5C3;

    x = 16'hA5C3;
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].start;
      ready = tbl[i].ready;
      cont  = tbl[i].cont;
      tick();
      check($sformatf("t1_sel_E%0d", i),   16'(sel1),   16'(tbl[i].sel));
      check($sformatf("t1_valid_E%0d", i), 16'(valid1), 16'(tbl[i].valid));
      check($sformatf("t1_busy_E%0d", i),  16'(busy1),  16'(tbl[i].busy));
      check($sformatf("t1_data_E%0d", i),  data1,       tbl[i].data);
    end

    // Settle 3: each sel held 3 cycles, word at E48.
    do_reset();
    x = 16'h8001;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_sel_E0", 16'(sel3), 16'h0);
    for (int n = 1; n <= 48; n++) begin
      tick();
      check($sformatf("t2_sel_E%0d", n), 16'(sel3), 16'((n / 3 > 15) ? 15 : n / 3));
      check($sformatf("t2_valid_E%0d", n), 16'(valid3), 16'(n == 48));
    end
    check("t2_data", data3, 16'h8001);
    check("t2_busy", 16'(busy3), 16'h0);

    // Continuous with ready low: first word held, FSM stalls in HOLD, second word not lost.
    do_reset();
    x = 16'hA5C3;
    cont  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 16; n++) tick();
    check("t3_first_valid", 16'(valid1), 16'h1);
    check("t3_first_data",  data1,       16'hA5C3);
    x = 16'h1234;
    begin
      int bad_stable;
      bad_stable = 0;
      for (int n = 17; n <= 56; n++) begin
        tick();
        if (data1 !== 16'hA5C3 || valid1 !== 1'b1) bad_stable++;
      end
      check("t3_word_stable_while_stalled", 16'(bad_stable), 16'h0);
    end
    check("t3_hold_busy", 16'(busy1), 16'h1);
    check("t3_hold_sel",  16'(sel1),  16'hF);
    cont  = 1'b0;
    ready = 1'b1;
    tick();
    check("t3_second_valid", 16'(valid1), 16'h1);
    check("t3_second_data",  data1,       16'h1234);
    check("t3_idle_busy",    16'(busy1),  16'h0);
    tick();
    check("t3_drained_valid", 16'(valid1), 16'h0);

    // Continuous, settle 2, ready high: words at E32 and E64, cont dropped after E40.
    do_reset();
    x = 16'hA5C3;
    cont  = 1'b1;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      tick();
      check($sformatf("t4_valid_E%0d", n), 16'(valid2), 16'(n == 32 || n == 64));
      check($sformatf("t4_busy_E%0d", n),  16'(busy2),  16'(n < 64));
      if (n == 32) begin
        check("t4_word0", data2, 16'hA5C3);
        x = 16'h1234;
      end
      if (n == 64) check("t4_word1", data2, 16'h1234);
      if (n == 40) cont = 1'b0;
    end

    // start re-asserted mid-scan is ignored: word still at E16.
    do_reset();
    x = 16'hA5C3;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      start = (n == 5);
      tick();
      check($sformatf("t5_valid_E%0d", n), 16'(valid1), 16'(n == 16));
    end
    start = 1'b0;
    check("t5_data", data1, 16'hA5C3);
    check("t5_sel",  16'(sel1), 16'hF);
    tick();

    // Asynchronous reset mid-scan, then a fresh scan.
    x = 16'h3C5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 7; n++) tick();
    check("t6_pre_reset_sel",  16'(sel1), 16'h7);
    check("t6_pre_reset_data", data1,     16'hA5C3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_sel",   16'(sel1),   16'h0);
    check("t6_async_data",  data1,       16'h0);
    check("t6_async_valid", 16'(valid1), 16'h0);
    check("t6_async_busy",  16'(busy1),  16'h0);
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 16; n++) tick();
    check("t6_fresh_valid", 16'(valid1), 16'h1);
    check("t6_fresh_data",  data1,       16'h3C5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
